// File: rtl/adsr_env_engine.sv
// Time-multiplexed ADSR envelope engine: one slot visit per cycle, two-cycle latency,
// with per-slot state, attenuation level and key history held in flops.
module adsr_env_engine #(
  parameter int NUM_SLOTS = 36,
  parameter int SLOT_W    = $clog2(NUM_SLOTS),
  parameter int ENV_WIDTH = 9,
  parameter int TIMER_W   = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic                 slot_valid,
  input  logic [SLOT_W-1:0]    slot,
  input  logic                 key_on,
  input  logic [3:0]           ar,
  input  logic [3:0]           dr,
  input  logic [3:0]           rr,
  input  logic [3:0]           sl,
  input  logic [5:0]           tl,
  input  logic                 egt,
  input  logic                 damp_en,
  input  logic [3:0]           rof,
  output logic                 out_valid,
  output logic [SLOT_W-1:0]    out_slot,
  output logic [ENV_WIDTH-1:0] env_out,
  output logic [2:0]           out_state,
  output logic                 pg_reset
);
  localparam logic [ENV_WIDTH-1:0] SILENCE = '1;
  localparam int STAGES = 1;

  typedef enum logic [2:0] {
    ATTACK  = 3'd0,
    DECAY   = 3'd1,
    SUSTAIN = 3'd2,
    RELEASE = 3'd3,
    DAMP    = 3'd4
  } env_state_t;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic              key_on;
    logic [3:0]        ar;
    logic [3:0]        dr;
    logic [3:0]        rr;
    logic [3:0]        sl;
    logic [5:0]        tl;
    logic              egt;
    logic              damp_en;
    logic [3:0]        rof;
  } req_t;

  logic [STAGES:0]                     vld_pipe;
  logic                                in_vld;
  req_t                                req_q;
  logic [TIMER_W-1:0]                  tmr_q;
  logic [NUM_SLOTS-1:0][2:0]           st_q;
  logic [NUM_SLOTS-1:0][ENV_WIDTH-1:0] lvl_q;
  logic [NUM_SLOTS-1:0]                kp_q;

  env_state_t           cur_st, nxt_st;
  logic [ENV_WIDTH-1:0] cur_lvl, nxt_lvl, thr, env_nxt;
  logic [ENV_WIDTH:0]   env_sum;
  logic                 cur_kp, nxt_pg;
  logic [2:0]           sh_ar, sh_dr, sh_rr;

  function automatic logic [2:0] step_shift(input logic [3:0] r, input logic [3:0] ofs,
                                            input logic [11:0] tmr);
    logic [6:0]  rsum;
    logic [3:0]  rh;
    logic [11:0] mask;
    rsum = {1'b0, r, 2'b00} + {3'b000, ofs};
    if (rsum > 7'd63) rsum = 7'd63;
    rh   = (r == 4'd0) ? 4'd0 : rsum[5:2];
    mask = (12'd1 << (4'd12 - rh)) - 12'd1;
    if (rh >= 4'd12)     step_shift = 3'(rh - 4'd11);
    else if (rh == 4'd0) step_shift = 3'd0;
    else                 step_shift = {2'b00, (tmr & mask) == 12'd0};
  endfunction

  function automatic logic [ENV_WIDTH-1:0] inc_lvl(input logic [ENV_WIDTH-1:0] l,
                                                   input logic [2:0] sh);
    logic [ENV_WIDTH:0] sum;
    sum = {1'b0, l} + ((ENV_WIDTH+1)'(1) << (sh - 3'd1));
    if (sh == 3'd0)                 inc_lvl = l;
    else if (sum > {1'b0, SILENCE}) inc_lvl = SILENCE;
    else                            inc_lvl = sum[ENV_WIDTH-1:0];
  endfunction

  // Exponential attack: subtract a fraction of the current level, floored at zero.
  function automatic logic [ENV_WIDTH-1:0] att_lvl(input logic [ENV_WIDTH-1:0] l,
                                                   input logic [2:0] sh);
    logic [ENV_WIDTH:0] dec;
    dec = {1'b0, l >> (3'd4 - sh)} + (ENV_WIDTH+1)'(1);
    if (sh == 3'd0)             att_lvl = l;
    else if (dec > {1'b0, l})   att_lvl = '0;
    else                        att_lvl = l - dec[ENV_WIDTH-1:0];
  endfunction

  assign in_vld    = slot_valid && (int'(slot) < NUM_SLOTS);
  assign out_valid = vld_pipe[STAGES];

  always_comb begin
    cur_st  = env_state_t'(st_q[req_q.slot]);
    cur_lvl = lvl_q[req_q.slot];
    cur_kp  = kp_q[req_q.slot];
    sh_ar   = step_shift(req_q.ar, req_q.rof, tmr_q[11:0]);
    sh_dr   = step_shift(req_q.dr, req_q.rof, tmr_q[11:0]);
    sh_rr   = step_shift(req_q.rr, req_q.rof, tmr_q[11:0]);
    thr     = (req_q.sl == 4'hF) ? SILENCE : (ENV_WIDTH'(req_q.sl) << (ENV_WIDTH - 5));
    nxt_st  = cur_st;
    nxt_lvl = cur_lvl;
    nxt_pg  = 1'b0;
    if (!req_q.key_on) begin
      nxt_st  = RELEASE;
      nxt_lvl = inc_lvl(cur_lvl, sh_rr);
    end else if (!cur_kp) begin
      if (req_q.damp_en && cur_lvl != SILENCE) begin
        nxt_st = DAMP;
      end else begin
        nxt_st = ATTACK;
        nxt_pg = 1'b1;
        if (req_q.ar == 4'hF) nxt_lvl = '0;
      end
    end else begin
      case (cur_st)
        DAMP: begin
          if (cur_lvl == SILENCE) begin
            nxt_st = ATTACK;
            nxt_pg = 1'b1;
            if (req_q.ar == 4'hF) nxt_lvl = '0;
          end else begin
            nxt_lvl = inc_lvl(cur_lvl, 3'd4);  // fixed rate 60 -> largest step
          end
        end
        ATTACK: begin
          if (cur_lvl == '0) nxt_st = DECAY;
          else               nxt_lvl = att_lvl(cur_lvl, sh_ar);
        end
        DECAY: begin
          if (cur_lvl >= thr) nxt_st = SUSTAIN;
          else                nxt_lvl = inc_lvl(cur_lvl, sh_dr);
        end
        SUSTAIN: begin
          if (!req_q.egt) nxt_lvl = inc_lvl(cur_lvl, sh_rr);
        end
        default: nxt_lvl = inc_lvl(cur_lvl, sh_rr);
      endcase
    end
    env_sum = {1'b0, nxt_lvl} + ((ENV_WIDTH+1)'(req_q.tl) << (ENV_WIDTH - 7));
    env_nxt = (env_sum > {1'b0, SILENCE}) ? SILENCE : env_sum[ENV_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      req_q     <= '0;
      tmr_q     <= '0;
      kp_q      <= '0;
      out_slot  <= '0;
      env_out   <= SILENCE;
      out_state <= RELEASE;
      pg_reset  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]  <= RELEASE;
        lvl_q[i] <= SILENCE;
      end
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_vld};
      if (frame_start) tmr_q <= tmr_q + TIMER_W'(1);
      if (in_vld) begin
        req_q.slot    <= slot;
        req_q.key_on  <= key_on;
        req_q.ar      <= ar;
        req_q.dr      <= dr;
        req_q.rr      <= rr;
        req_q.sl      <= sl;
        req_q.tl      <= tl;
        req_q.egt     <= egt;
        req_q.damp_en <= damp_en;
        req_q.rof     <= rof;
      end
      // Writeback and output capture share an edge, so a repeat visit next cycle sees fresh state.
      if (vld_pipe[0]) begin
        st_q[req_q.slot]  <= nxt_st;
        lvl_q[req_q.slot] <= nxt_lvl;
        kp_q[req_q.slot]  <= req_q.key_on;
        out_slot          <= req_q.slot;
        env_out           <= env_nxt;
        out_state         <= nxt_st;
        pg_reset          <= nxt_pg;
      end
    end
  end
endmodule

// File: tb/tb_adsr_env_engine.sv
// Scoreboard bench for adsr_env_engine: a behavioural model queues expected results per
// visit, a negedge monitor queues observed results, each scenario drains and compares.
module tb_adsr_env_engine;
  localparam int NS  = 36;
  localparam int SIL = 511;

  logic       clk = 1'b0, reset_n = 1'b1, frame_start = 1'b0, slot_valid = 1'b0;
  logic [5:0] slot = '0;
  logic       key_on = 1'b0, egt = 1'b0, damp_en = 1'b0;
  logic [3:0] ar = '0, dr = '0, rr = '0, sl = '0, rof = '0;
  logic [5:0] tl = '0;
  logic       out_valid, pg_reset;
  logic [5:0] out_slot;
  logic [8:0] env_out;
  logic [2:0] out_state;

  adsr_env_engine #(.NUM_SLOTS(36), .SLOT_W(6), .ENV_WIDTH(9), .TIMER_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .slot_valid(slot_valid),
    .slot(slot), .key_on(key_on), .ar(ar), .dr(dr), .rr(rr), .sl(sl), .tl(tl), .egt(egt),
    .damp_en(damp_en), .rof(rof), .out_valid(out_valid), .out_slot(out_slot),
    .env_out(env_out), .out_state(out_state), .pg_reset(pg_reset)
  );

  always #5 clk = ~clk;

  typedef struct { int slot; int env; int st; int pg; } res_t;
  res_t exp_q[$];
  res_t obs_q[$];
  int m_st[NS], m_lvl[NS], m_kp[NS], m_tmr;
  int n_chk = 0, n_fail = 0;

  always @(negedge clk)
    if (out_valid === 1'b1)
      obs_q.push_back('{int'(out_slot), int'(env_out), int'(out_state), int'(pg_reset)});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int shf(int r);
    int big_r, rh;
    if (r == 0) return 0;
    big_r = 4 * r + int'(rof);
    if (big_r > 63) big_r = 63;
    rh = big_r / 4;
    if (rh >= 12) return rh - 11;
    return ((m_tmr % (1 << (12 - rh))) == 0) ? 1 : 0;
  endfunction

  function automatic int incr(int l, int sh);
    if (sh == 0) return l;
    return (l + (1 << (sh - 1)) > SIL) ? SIL : l + (1 << (sh - 1));
  endfunction

  function automatic int att(int l, int sh);
    int d;
    if (sh == 0) return l;
    d = (l >> (4 - sh)) + 1;
    return (d > l) ? 0 : l - d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin m_st[i] = 3; m_lvl[i] = SIL; m_kp[i] = 0; end
    m_tmr = 0;
  endtask

  task automatic model_visit(int s);
    int st, lv, pg, thr, e;
    st = m_st[s]; lv = m_lvl[s]; pg = 0;
    thr = (sl == 4'hF) ? SIL : int'(sl) * 16;
    if (!key_on) begin st = 3; lv = incr(lv, shf(int'(rr))); end
    else if (m_kp[s] == 0) begin
      if (damp_en && lv < SIL) st = 4;
      else begin st = 0; pg = 1; if (ar == 4'hF) lv = 0; end
    end
    else if (st == 4) begin
      if (lv == SIL) begin st = 0; pg = 1; if (ar == 4'hF) lv = 0; end
      else lv = incr(lv, 4);
    end
    else if (st == 0) begin if (lv == 0) st = 1; else lv = att(lv, shf(int'(ar))); end
    else if (st == 1) begin if (lv >= thr) st = 2; else lv = incr(lv, shf(int'(dr))); end
    else if (st == 2) begin if (!egt) lv = incr(lv, shf(int'(rr))); end
    else lv = incr(lv, shf(int'(rr)));
    m_st[s] = st; m_lvl[s] = lv; m_kp[s] = int'(key_on);
    e = lv + int'(tl) * 4;
    exp_q.push_back('{s, (e > SIL) ? SIL : e, st, pg});
  endtask

  // ---------------- stimulus ----------------
  task automatic visit(input int s, input logic k, input logic fs);
    @(negedge clk);
    slot = 6'(s); key_on = k; frame_start = fs; slot_valid = 1'b1;
    if (fs) m_tmr = (m_tmr + 1) % 4096;
    if (s < NS) model_visit(s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); slot_valid = 1'b0; frame_start = 1'b0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    slot_valid = 1'b0; frame_start = 1'b0; reset_n = 1'b0;
    exp_q.delete(); obs_q.delete(); model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    res_t e, o;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || env_out !== 9'd511 || out_state !== 3'd3 || pg_reset !== 1'b0 || out_slot !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_values: got v%0b env %0d st %0d pg %0b slot %0d, required v0 env 511 st 3 pg 0 slot 0",
               out_valid, env_out, out_state, pg_reset, out_slot);
    end
    @(negedge clk) reset_n = 1'b1;
    ar = 4'hF;
    visit(2, 1'b1, 1'b0); visit(2, 1'b1, 1'b0); visit(2, 1'b1, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0; slot_valid = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || env_out !== 9'd511) begin
      n_fail++;
      $display("FAIL reset_midstream: got v%0b env %0d, required v0 env 511", out_valid, env_out);
    end
    exp_q.delete(); obs_q.delete(); model_reset();
    @(negedge clk) reset_n = 1'b1;
    idle(3);
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_discard: got %0d results after reset, required 0", obs_q.size());
    end
    visit(5, 1'b0, 1'b0);
    idle(1);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_latency1: got out_valid %0b one cycle after visit, required 0", out_valid);
    end
    idle(1);
    n_chk++;
    if (out_valid !== 1'b1 || env_out !== 9'd511 || out_state !== 3'd3 || out_slot !== 6'd5) begin
      n_fail++;
      $display("FAIL reset_visit5: got v%0b env %0d st %0d slot %0d, required v1 env 511 st 3 slot 5",
               out_valid, env_out, out_state, out_slot);
    end
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL reset_sb: missing result, required env %0d", e.env); end
      else begin
        o = obs_q.pop_front();
        if (o.slot != e.slot || o.env != e.env || o.st != e.st || o.pg != e.pg) begin
          n_fail++;
          $display("FAIL reset_sb: got s%0d env %0d st %0d pg %0d, required s%0d env %0d st %0d pg %0d",
                   o.slot, o.env, o.st, o.pg, e.slot, e.env, e.st, e.pg);
        end
      end
    end
  endtask

  task automatic test_instant_attack_decay();
    res_t got[$]; res_t e, o;
    int env_tbl[17];
    int st_tbl[17];
    env_tbl = '{0, 0, 8, 16, 24, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32};
    st_tbl  = '{0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    ar = 4'hF; dr = 4'hF; sl = 4'd2; tl = '0; rof = '0; egt = 1'b1; damp_en = 1'b0;
    for (int i = 0; i < 17; i++) visit(0, 1'b1, 1'b0);
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL instant_sb: missing result, required env %0d", e.env); end
      else begin
        o = obs_q.pop_front(); got.push_back(o);
        if (o.slot != e.slot || o.env != e.env || o.st != e.st || o.pg != e.pg) begin
          n_fail++;
          $display("FAIL instant_sb: got s%0d env %0d st %0d pg %0d, required s%0d env %0d st %0d pg %0d",
                   o.slot, o.env, o.st, o.pg, e.slot, e.env, e.st, e.pg);
        end
      end
    end
    for (int i = 0; i < 17; i++) begin
      n_chk++;
      if (got[i].env != env_tbl[i] || got[i].st != st_tbl[i] || got[i].pg != ((i == 0) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL instant_tbl[%0d]: got env %0d st %0d pg %0d, required env %0d st %0d pg %0d",
                 i, got[i].env, got[i].st, got[i].pg, env_tbl[i], st_tbl[i], (i == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_release_saturation();
    res_t got[$]; res_t e, o;
    rr = 4'hF;
    for (int i = 0; i < 61; i++) visit(0, 1'b0, 1'b0);
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL release_sb: missing result, required env %0d", e.env); end
      else begin
        o = obs_q.pop_front(); got.push_back(o);
        if (o.slot != e.slot || o.env != e.env || o.st != e.st || o.pg != e.pg) begin
          n_fail++;
          $display("FAIL release_sb: got s%0d env %0d st %0d pg %0d, required s%0d env %0d st %0d pg %0d",
                   o.slot, o.env, o.st, o.pg, e.slot, e.env, e.st, e.pg);
        end
      end
    end
    n_chk++;
    if (got[0].env != 40 || got[58].env != 504 || got[59].env != 511 || got[60].env != 511 || got[60].st != 3) begin
      n_fail++;
      $display("FAIL release_clamp: got %0d/%0d/%0d/%0d st %0d, required 40/504/511/511 st 3",
               got[0].env, got[58].env, got[59].env, got[60].env, got[60].st);
    end
  endtask

  task automatic test_damp();
    res_t got[$]; res_t e, o;
    ar = 4'hF; damp_en = 1'b0; tl = '0; rof = '0;
    visit(1, 1'b1, 1'b0);
    rr = 4'd14;
    for (int i = 0; i < 25; i++) visit(1, 1'b0, 1'b0);
    damp_en = 1'b1;
    for (int i = 0; i < 54; i++) visit(1, 1'b1, 1'b0);
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL damp_sb: missing result, required env %0d", e.env); end
      else begin
        o = obs_q.pop_front(); got.push_back(o);
        if (o.slot != e.slot || o.env != e.env || o.st != e.st || o.pg != e.pg) begin
          n_fail++;
          $display("FAIL damp_sb: got s%0d env %0d st %0d pg %0d, required s%0d env %0d st %0d pg %0d",
                   o.slot, o.env, o.st, o.pg, e.slot, e.env, e.st, e.pg);
        end
      end
    end
    n_chk++;
    if (got[25].env != 100 || got[25].st != 3) begin
      n_fail++; $display("FAIL damp_pre: got env %0d st %0d, required env 100 st 3", got[25].env, got[25].st);
    end
    n_chk++;
    if (got[26].env != 100 || got[26].st != 4 || got[26].pg != 0) begin
      n_fail++;
      $display("FAIL damp_entry: got env %0d st %0d pg %0d, required env 100 st 4 pg 0", got[26].env, got[26].st, got[26].pg);
    end
    n_chk++;
    if (got[27].env != 108 || got[77].env != 508 || got[78].env != 511 || got[78].st != 4) begin
      n_fail++;
      $display("FAIL damp_ramp: got %0d/%0d/%0d st %0d, required 108/508/511 st 4",
               got[27].env, got[77].env, got[78].env, got[78].st);
    end
    n_chk++;
    if (got[79].env != 0 || got[79].st != 0 || got[79].pg != 1) begin
      n_fail++;
      $display("FAIL damp_reattack: got env %0d st %0d pg %0d, required env 0 st 0 pg 1", got[79].env, got[79].st, got[79].pg);
    end
  endtask

  task automatic test_back_to_back();
    res_t got[$]; res_t e, o;
    int env_a, env_b;
    ar = 4'hF; dr = 4'hF; sl = 4'hF; egt = 1'b0; damp_en = 1'b0; tl = '0;
    visit(7, 1'b1, 1'b0); visit(7, 1'b1, 1'b0);
    idle(3);
    visit(7, 1'b1, 1'b0); visit(7, 1'b1, 1'b0);
    idle(1);
    env_a = int'(env_out);
    n_chk++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_t2: got out_valid %0b, required 1", out_valid); end
    idle(1);
    env_b = int'(env_out);
    n_chk++;
    if (out_valid !== 1'b1 || env_b - env_a != 8) begin
      n_fail++; $display("FAIL b2b_t3: got v%0b step %0d, required v1 step 8", out_valid, env_b - env_a);
    end
    idle(1);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_t4: got out_valid %0b, required 0", out_valid); end
    tl = 6'd63;
    visit(7, 1'b1, 1'b0);
    visit(40, 1'b1, 1'b0);
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb: missing result, required env %0d", e.env); end
      else begin
        o = obs_q.pop_front(); got.push_back(o);
        if (o.slot != e.slot || o.env != e.env || o.st != e.st || o.pg != e.pg) begin
          n_fail++;
          $display("FAIL b2b_sb: got s%0d env %0d st %0d pg %0d, required s%0d env %0d st %0d pg %0d",
                   o.slot, o.env, o.st, o.pg, e.slot, e.env, e.st, e.pg);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_badslot: got %0d extra results, required 0", obs_q.size());
    end
    n_chk++;
    if (got[4].env != 276 || got[4].st != 1) begin
      n_fail++; $display("FAIL b2b_tl: got env %0d st %0d, required env 276 st 1", got[4].env, got[4].st);
    end
    tl = '0;
  endtask

  task automatic test_timer_gating();
    res_t got[$]; res_t e, o;
    do_reset();
    ar = 4'hF; rof = '0; damp_en = 1'b0; tl = '0;
    visit(3, 1'b1, 1'b0);
    rr = 4'd4;
    for (int i = 0; i < 1024; i++) visit(3, 1'b0, 1'b1);
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL timer_sb: missing result, required env %0d", e.env); end
      else begin
        o = obs_q.pop_front(); got.push_back(o);
        if (o.slot != e.slot || o.env != e.env || o.st != e.st || o.pg != e.pg) begin
          n_fail++;
          $display("FAIL timer_sb: got s%0d env %0d st %0d pg %0d, required s%0d env %0d st %0d pg %0d",
                   o.slot, o.env, o.st, o.pg, e.slot, e.env, e.st, e.pg);
        end
      end
    end
    n_chk++;
    if (got[255].env != 0 || got[256].env != 1 || got[1024].env != 4 || got[1024].st != 3) begin
      n_fail++;
      $display("FAIL timer_gate: got %0d/%0d/%0d st %0d, required 0/1/4 st 3",
               got[255].env, got[256].env, got[1024].env, got[1024].st);
    end
  endtask

  initial begin
    test_reset();
    test_instant_attack_decay();
    test_release_saturation();
    test_damp();
    test_back_to_back();
    test_timer_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
